// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants and types for the frame-buffer write scheduler
// Purpose: default frame geometry, default brush edge, scheduler state enum and
// the packed colour record used for the write data path.
package fb_pkg;
  localparam int W_RES   = 640;
  localparam int H_RES   = 480;
  localparam int COORD_W = 11;
  localparam int BRUSH   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    STAMP = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
endpackage

// File: rtl/fb_write_sched_if.sv
// rtl/fb_write_sched_if.sv - request and write-port bundle of the frame-buffer scheduler
// Purpose: groups the clear/stamp request handshakes and the shared buffer write port.
// Ports (master = scheduler side):
//   in : clear_req, clear_rgb, stamp_req, stamp_x, stamp_y, stamp_rgb
//   out: stamp_ack, busy, done, wr_en, wr_x, wr_y, wr_r, wr_g, wr_b
interface fb_write_sched_if #(
  parameter int COORD_W = 11
);
  logic               clear_req;
  logic [23:0]        clear_rgb;
  logic               stamp_req;
  logic [COORD_W-1:0] stamp_x;
  logic [COORD_W-1:0] stamp_y;
  logic [23:0]        stamp_rgb;
  logic               stamp_ack;
  logic               busy;
  logic               done;
  logic               wr_en;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [7:0]         wr_r;
  logic [7:0]         wr_g;
  logic [7:0]         wr_b;

  modport master (
    input  clear_req, clear_rgb, stamp_req, stamp_x, stamp_y, stamp_rgb,
    output stamp_ack, busy, done, wr_en, wr_x, wr_y, wr_r, wr_g, wr_b
  );

  modport slave (
    output clear_req, clear_rgb, stamp_req, stamp_x, stamp_y, stamp_rgb,
    input  stamp_ack, busy, done, wr_en, wr_x, wr_y, wr_r, wr_g, wr_b
  );
endinterface

// File: rtl/fb_write_sched_rect_sweeper.sv
// rtl/fb_write_sched_rect_sweeper.sv - raster counter over an axis-aligned rectangle
// Purpose: on start, walks x0..x0+w-1 (fastest) then y0..y0+h-1, one point per cycle.
// Ports:
//   in : clk_i, rst_i (sync, active-high), start_i, x0_i, y0_i, w_i, h_i (w,h >= 1)
//   out: x_o, y_o (current point), valid_o (point is live), last_o (final point)
module rect_sweeper #(
  parameter int COORD_W = 11
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] w_i,
  input  logic [COORD_W-1:0] h_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               valid_o,
  output logic               last_o
);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ye_q, ye_d;
  logic               valid_q, valid_d;

  // Inclusive end points are stored so the counters stop at the edge and never wrap.
  assign last_o = valid_q && (x_q == xe_q) && (y_q == ye_q);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    valid_d = valid_q;
    if (start_i) begin
      x_d     = x0_i;
      y_d     = y0_i;
      xs_d    = x0_i;
      xe_d    = x0_i + w_i - ONE;
      ye_d    = y0_i + h_i - ONE;
      valid_d = 1'b1;
    end else if (valid_q) begin
      if (last_o) begin
        valid_d = 1'b0;
      end else if (x_q == xe_q) begin
        x_d = xs_q;
        y_d = y_q + ONE;
      end else begin
        x_d = x_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q     <= '0;
      y_q     <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      valid_q <= valid_d;
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fb_write_sched.sv
// rtl/fb_write_sched.sv - single-owner write-port scheduler for the RGB frame buffers
// Purpose: arbitrates full-frame clears (priority) and BRUSHxBRUSH stamps onto one
// write port, one pixel per clock, through a shared rectangle sweeper.
// Ports:
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high
//   bus      : fb_write_sched_if.master (requests in; ack/busy/done and write port out)
module fb_write_sched #(
  parameter int W_RES   = fb_pkg::W_RES,
  parameter int H_RES   = fb_pkg::H_RES,
  parameter int BRUSH   = fb_pkg::BRUSH,
  parameter int COORD_W = fb_pkg::COORD_W
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  fb_write_sched_if.master   bus
);
  import fb_pkg::*;

  localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(W_RES - BRUSH);
  localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(H_RES - BRUSH);
  localparam logic [COORD_W-1:0] W_FULL = COORD_W'(W_RES);
  localparam logic [COORD_W-1:0] H_FULL = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] SIDE   = COORD_W'(BRUSH);

  state_t state_q, state_d;
  logic   pend_q, pend_d;
  rgb_t   rgb_q, rgb_d;
  logic   ack_q, ack_d;
  logic   done_q, done_d;

  logic               sw_start;
  logic [COORD_W-1:0] sw_x0, sw_y0, sw_w, sw_h;
  logic [COORD_W-1:0] sw_x, sw_y;
  logic               sw_valid, sw_last;
  logic [COORD_W-1:0] x_cl, y_cl;

  // Keep the whole stamp on screen by pulling the origin back from the far edges.
  assign x_cl = (bus.stamp_x > X_MAX) ? X_MAX : bus.stamp_x;
  assign y_cl = (bus.stamp_y > Y_MAX) ? Y_MAX : bus.stamp_y;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    rgb_d    = rgb_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    sw_start = 1'b0;
    sw_x0    = '0;
    sw_y0    = '0;
    sw_w     = W_FULL;
    sw_h     = H_FULL;

    // A clear already in progress makes a further clear request redundant.
    if (bus.clear_req && (state_q != CLEAR)) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.clear_req || pend_q) begin
          state_d  = CLEAR;
          pend_d   = 1'b0;
          sw_start = 1'b1;
          rgb_d    = bus.clear_rgb;
        end else if (bus.stamp_req) begin
          state_d  = STAMP;
          sw_start = 1'b1;
          sw_x0    = x_cl;
          sw_y0    = y_cl;
          sw_w     = SIDE;
          sw_h     = SIDE;
          rgb_d    = bus.stamp_rgb;
          ack_d    = 1'b1;
        end
      end
      CLEAR, STAMP: begin
        if (sw_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      rgb_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rgb_q   <= rgb_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  rect_sweeper #(.COORD_W(COORD_W)) u_sweep (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .start_i (sw_start),
    .x0_i    (sw_x0),
    .y0_i    (sw_y0),
    .w_i     (sw_w),
    .h_i     (sw_h),
    .x_o     (sw_x),
    .y_o     (sw_y),
    .valid_o (sw_valid),
    .last_o  (sw_last)
  );

  assign bus.wr_en     = sw_valid;
  assign bus.busy      = sw_valid;
  assign bus.wr_x      = sw_x;
  assign bus.wr_y      = sw_y;
  assign bus.wr_r      = rgb_q.r;
  assign bus.wr_g      = rgb_q.g;
  assign bus.wr_b      = rgb_q.b;
  assign bus.stamp_ack = ack_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_fb_write_sched.sv
// tb/tb_fb_write_sched.sv - self-checking bench for fb_write_sched
// Purpose: full-size instance for stamps and clamping, 16x8 instance (brush 3) for
// clears, arbitration, absorption and reset; expected writes come from raster math.
module tb_fb_write_sched;
  logic CLOCK_50 = 1'b0;
  logic reset;
  always #10 CLOCK_50 = ~CLOCK_50;

  fb_write_sched_if #(.COORD_W(11)) b_if ();
  fb_write_sched_if #(.COORD_W(11)) s_if ();

  fb_write_sched #(.W_RES(640), .H_RES(480), .BRUSH(8), .COORD_W(11)) dut_big (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (b_if.master)
  );

  fb_write_sched #(.W_RES(16), .H_RES(8), .BRUSH(3), .COORD_W(11)) dut_small (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (s_if.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    int          ex0;
    int          ey0;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {wr_en, busy, stamp_ack, done, wr_x, wr_y, r, g, b}
  function automatic logic [49:0] snap(input bit s);
    if (s) return {s_if.wr_en, s_if.busy, s_if.stamp_ack, s_if.done,
                   s_if.wr_x, s_if.wr_y, s_if.wr_r, s_if.wr_g, s_if.wr_b};
    return {b_if.wr_en, b_if.busy, b_if.stamp_ack, b_if.done,
            b_if.wr_x, b_if.wr_y, b_if.wr_r, b_if.wr_g, b_if.wr_b};
  endfunction

  function automatic int clampv(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic set_clear(input bit s, input logic req);
    if (s) s_if.clear_req = req; else b_if.clear_req = req;
  endtask

  task automatic set_clear_rgb(input bit s, input logic [23:0] rgb);
    if (s) s_if.clear_rgb = rgb; else b_if.clear_rgb = rgb;
  endtask

  task automatic set_stamp_req(input bit s, input logic req);
    if (s) s_if.stamp_req = req; else b_if.stamp_req = req;
  endtask

  task automatic set_stamp(input bit s, input int x, input int y, input logic [23:0] rgb);
    if (s) begin
      s_if.stamp_x = 11'(x); s_if.stamp_y = 11'(y); s_if.stamp_rgb = rgb; s_if.stamp_req = 1'b1;
    end else begin
      b_if.stamp_x = 11'(x); b_if.stamp_y = 11'(y); b_if.stamp_rgb = rgb; b_if.stamp_req = 1'b1;
    end
  endtask

  // Call at the negedge where the request was driven; checks w*h raster writes
  // in the following cycles, then the done cycle. Optionally pulses clear_req
  // right after write number inj.
  task automatic expect_writes(input bit s, input int x0, input int y0, input int w, input int h,
                               input logic [23:0] rgb, input bit want_ack, input int inj,
                               input logic [23:0] inj_rgb, input string name);
    logic [49:0] a, e;
    for (int k = 0; k < w * h; k++) begin
      @(negedge CLOCK_50);
      a = snap(s);
      set_clear(s, k == inj);
      if (k == inj) set_clear_rgb(s, inj_rgb);
      if (want_ack && k == 0) set_stamp_req(s, 1'b0);
      e = {1'b1, 1'b1, (want_ack && k == 0), 1'b0, 11'(x0 + k % w), 11'(y0 + k / w), rgb};
      check($sformatf("%s_px%0d", name, k), 64'(a), 64'(e));
    end
    @(negedge CLOCK_50);
    a = snap(s);
    set_clear(s, 1'b0);
    check({name, "_done"}, 64'(a[49:46]), 64'(4'b0001));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [49:0] a;
    int x, y;
    logic [23:0] rgb;

    reset = 1'b1;
    b_if.clear_req = 0; b_if.clear_rgb = 0; b_if.stamp_req = 0;
    b_if.stamp_x = 0; b_if.stamp_y = 0; b_if.stamp_rgb = 0;
    s_if.clear_req = 0; s_if.clear_rgb = 0; s_if.stamp_req = 0;
    s_if.stamp_x = 0; s_if.stamp_y = 0; s_if.stamp_rgb = 0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_big", 64'(snap(0)), 64'(0));
    check("reset_small", 64'(snap(1)), 64'(0));
    reset = 1'b0;

    // Stamps on the full-size frame: {x, y, rgb, expected origin}
    vecs[0] = '{316, 236, 24'hF80000, 316, 236};
    vecs[1] = '{636, 478, 24'h00FC00, 632, 472};
    vecs[2] = '{0,   0,   24'h0000F8, 0,   0};
    vecs[3] = '{632, 472, 24'h123456, 632, 472};
    vecs[4] = '{2047, 2047, 24'hFFFFFF, 632, 472};
    vecs[5] = '{633, 100, 24'hA5A5A5, 632, 100};
    vecs[6] = '{5,   473, 24'h0F0F0F, 5,   472};
    for (int i = 0; i < 7; i++) begin
      set_stamp(0, vecs[i].x, vecs[i].y, vecs[i].rgb);
      expect_writes(0, vecs[i].ex0, vecs[i].ey0, 8, 8, vecs[i].rgb, 1'b1, -1, 24'h0,
                    $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      x = int'($urandom_range(0, 2047));
      y = int'($urandom_range(0, 2047));
      rgb = 24'($urandom);
      set_stamp(0, x, y, rgb);
      expect_writes(0, clampv(x, 632), clampv(y, 472), 8, 8, rgb, 1'b1, -1, 24'h0,
                    $sformatf("rnd_big%0d", i));
    end

    // Reset mid-job: big instance clearing, small instance stamping with a clear pending.
    set_clear_rgb(0, 24'h123456);
    set_clear(0, 1'b1);
    set_stamp(1, 5, 5, 24'h00AA00);
    @(negedge CLOCK_50);
    check("rst_big_w0", 64'(snap(0)), 64'({4'b1100, 11'd0, 11'd0, 24'h123456}));
    check("rst_small_w0", 64'(snap(1)), 64'({4'b1110, 11'd5, 11'd5, 24'h00AA00}));
    set_clear(0, 1'b0);
    set_stamp_req(1, 1'b0);
    set_clear(1, 1'b1);
    @(negedge CLOCK_50);
    check("rst_big_w1", 64'(snap(0)), 64'({4'b1100, 11'd1, 11'd0, 24'h123456}));
    set_clear(1, 1'b0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("rst_big_zero", 64'(snap(0)), 64'(0));
    check("rst_small_zero", 64'(snap(1)), 64'(0));
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      check("post_rst_big", 64'(snap(0)), 64'(0));
      check("post_rst_small", 64'(snap(1)), 64'(0));
    end

    // Full clear on the 16x8 frame.
    set_clear_rgb(1, 24'h000000);
    set_clear(1, 1'b1);
    expect_writes(1, 0, 0, 16, 8, 24'h000000, 1'b0, -1, 24'h0, "clear0");

    // Simultaneous requests: clear wins, stamp acknowledged the cycle after done.
    set_clear_rgb(1, 24'h00FF00);
    set_clear(1, 1'b1);
    set_stamp(1, 20, 3, 24'h0000AA);
    expect_writes(1, 0, 0, 16, 8, 24'h00FF00, 1'b0, -1, 24'h0, "prio_clear");
    expect_writes(1, 13, 3, 3, 3, 24'h0000AA, 1'b1, -1, 24'h0, "prio_stamp");

    // Clear during a stamp, then a second clear during that clear is absorbed.
    set_stamp(1, 2, 6, 24'hABCDEF);
    expect_writes(1, 2, 5, 3, 3, 24'hABCDEF, 1'b1, 4, 24'h111111, "stamp_w_clr");
    expect_writes(1, 0, 0, 16, 8, 24'h111111, 1'b0, 30, 24'h222222, "clr_absorb");
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      a = snap(1);
      check("no_third_job", 64'(a[49:46]), 64'(0));
    end

    // Random mix of clears and stamps on the small frame.
    for (int i = 0; i < 12; i++) begin
      rgb = 24'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        set_clear_rgb(1, rgb);
        set_clear(1, 1'b1);
        expect_writes(1, 0, 0, 16, 8, rgb, 1'b0, -1, 24'h0, $sformatf("rnd_clr%0d", i));
      end else begin
        x = int'($urandom_range(0, 31));
        y = int'($urandom_range(0, 31));
        set_stamp(1, x, y, rgb);
        expect_writes(1, clampv(x, 13), clampv(y, 5), 3, 3, rgb, 1'b1, -1, 24'h0,
                      $sformatf("rnd_st%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fb_write_sched.md
# fb_write_sched

Write-port scheduler for the three per-colour frame buffers (red, green, blue). It is the single owner of the shared write address, data and enable. It sequences two job types onto that port: a full-screen clear and a BRUSH×BRUSH brush stamp at the cursor. Clear requests come from the reset/clear path and stamp requests from the cursor/paint controller; the block emits exactly one pixel write per clock while a job runs.

## Interface
Parameters:
- W_RES, 640, frame width in pixels
- H_RES, 480, frame height in pixels
- BRUSH, 8, stamp edge length in pixels (1 ≤ BRUSH ≤ min(W_RES, H_RES))
- COORD_W, 11, coordinate width

Ports:
- CLOCK_50  in  1  system clock; single clock domain
- reset  in  1  reset, synchronous, active-high
- clear_req  in  1  one-cycle pulse; requests a full-frame clear
- clear_rgb  in  24  clear colour {R,G,B}, sampled when the clear starts
- stamp_req  in  1  level; held high until stamp_ack
- stamp_x, stamp_y  in  COORD_W each  requested top-left corner of the stamp
- stamp_rgb  in  24  brush colour {R,G,B}
- stamp_ack  out  1  one-cycle pulse; stamp parameters captured
- busy  out  1  high while a job is issuing writes
- done  out  1  one-cycle pulse after the last write of a job
- wr_en  out  1  buffer write enable
- wr_x, wr_y  out  COORD_W each  write address
- wr_r, wr_g, wr_b  out  8 each  write data

## Operation
- States:
  - IDLE: no writes issued.
  - CLEAR: sweeps x 0..W_RES-1 (fastest), y 0..H_RES-1.
  - STAMP: sweeps x x0..x0+BRUSH-1 (fastest), y y0..y0+BRUSH-1.
- clear_pending flag:
  - Set by clear_req in any state except CLEAR. A clear_req arriving during CLEAR is absorbed.
  - Cleared when CLEAR is entered.
- IDLE arbitration, evaluated at each edge:
  - If clear_req or clear_pending → CLEAR. Clear has priority over stamp.
  - Else if stamp_req → STAMP. The block captures the clamped origin and stamp_rgb and asserts stamp_ack.
- stamp_req while busy is not acknowledged. The requester holds it, and it is served after the current job.
- Origin clamping:
  - x0 = min(stamp_x, W_RES-BRUSH).
  - y0 = min(stamp_y, H_RES-BRUSH).
- Arithmetic: counters are COORD_W wide and never wrap. Comparisons are unsigned.
- On the last pixel, the state returns to IDLE and done pulses.
- Write data:
  - Constant for the whole job.
  - Taken from clear_rgb or stamp_rgb as sampled at job start.
- reset mid-job:
  - Abandons the job; done is not pulsed.
  - clear_pending is cleared.
- Reset values: state IDLE, clear_pending 0, and all outputs 0 (wr_en, wr_x, wr_y, wr_r/g/b, busy, done, stamp_ack).

## Timing
- All outputs are registered.
- Start latency: a request sampled at edge t gives the first write and stamp_ack in cycle t+1.
- Write run: a job of N pixels holds wr_en high for cycles t+1..t+N, one address per cycle, with no bubbles.
  - Clear: N = W_RES·H_RES.
  - Stamp: N = BRUSH².
- busy is high exactly when wr_en is high.
- done is high in cycle t+N+1.
- Back-to-back: the earliest next job starts writing in cycle t+N+2. This gives one idle cycle between jobs.
- stamp_ack is high for exactly one cycle. The requester drops stamp_req at the next edge.

## Structure
- Package fb_pkg holds:
  - W_RES, H_RES, COORD_W and the default BRUSH
  - the state enum {IDLE, CLEAR, STAMP}
  - the rgb_t struct {r,g,b 8 bits}
- Sub-module rect_sweeper:
  - Inputs: start, x0, y0, w, h.
  - Outputs: x, y, valid, last.
  - Generic raster counter, instantiated once and shared by both job types.
- Top level: arbitration FSM, pending flag, capture registers, output registers.

## Test plan
- Reset: assert reset for 3 cycles during a clear → next cycle all outputs 0; no done; no further writes after release.
- Stamp at (316,236), rgb 0xF80000:
  - stamp_ack in cycle 1.
  - 64 writes, x 316..323 and y 236..243 in raster order, all with wr_r=0xF8 and g=b=0.
  - done in cycle 65.
- Clamp: stamp at (636,478) → writes cover x 632..639, y 472..479; no address ≥ 640/480.
- Clear, with W_RES=16 and H_RES=8 in simulation, clear_rgb 0 → 128 consecutive writes (0,0)..(15,7), then done.
- Simultaneous clear_req and stamp_req in IDLE:
  - Clear runs first.
  - stamp_ack occurs 1 cycle after the clear's done.
  - The stamp then completes.
- clear_req during a stamp, and a second clear_req during the clear:
  - The stamp finishes and exactly one clear follows.
  - The second request is absorbed, with no third job.
